// File: rtl/slow_clock.sv
// ============================================================================
//  Module   : slow_clock
//  Purpose  : Divides the system clock by SlowFactor into a registered,
//             glitch-free square wave (high phase gets the extra odd cycle).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_clock #(
    parameter int SlowFactor = 8
) (
    input  logic clock,
    input  logic reset,
    output logic outclock
);

    localparam int c_LOW  = SlowFactor / 2;
    localparam int c_HIGH = SlowFactor - c_LOW;
    localparam int c_CW   = (c_HIGH > 1) ? $clog2(c_HIGH) : 1;

    localparam logic [c_CW-1:0] c_LOW_LAST  = c_CW'(c_LOW - 1);
    localparam logic [c_CW-1:0] c_HIGH_LAST = c_CW'(c_HIGH - 1);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    generate
        if (SlowFactor < 2) begin : g_bad_factor
            $error("slow_clock: SlowFactor must be >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [c_CW-1:0]   cnt_q,   cnt_d;
    logic              outclock_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            outclock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            outclock_q <= (state_d == ST_HIGH);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + c_ONE;
        case (state_q)
            ST_LOW: begin
                if (cnt_q == c_LOW_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_HIGH: begin
                if (cnt_q == c_HIGH_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output taken straight from its own flop so no logic sits after it.
    assign outclock = outclock_q;

endmodule

`default_nettype wire

// File: tb/tb_slow_clock.sv
// ============================================================================
//  Module   : tb_slow_clock
//  Purpose  : Directed self-checking bench for slow_clock at F = 8, 5 and 2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slow_clock;

    logic clock;
    logic reset;
    logic out8, out5, out2;

    int errors = 0;
    int checks = 0;

    slow_clock #(.SlowFactor(8)) u_dut8 (.clock(clock), .reset(reset), .outclock(out8));
    slow_clock #(.SlowFactor(5)) u_dut5 (.clock(clock), .reset(reset), .outclock(out5));
    slow_clock #(.SlowFactor(2)) u_dut2 (.clock(clock), .reset(reset), .outclock(out2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected level after edge n (n counted from reset release, edge 1 first).
    function automatic int model(input int f, input int n);
        if (n == 0) return 0;
        return ((n % f) >= (f / 2)) ? 1 : 0;
    endfunction

    task automatic hold_reset(input int cycles);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_value("rst_async_f8", int'(out8), 0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check_value($sformatf("rst_hold_f8_%0d", i), int'(out8), 0);
            check_value($sformatf("rst_hold_f5_%0d", i), int'(out5), 0);
            check_value($sformatf("rst_hold_f2_%0d", i), int'(out2), 0);
        end
        reset = 1'b1;
    endtask

    task automatic run_checked(input int edges);
        for (int n = 1; n <= edges; n++) begin
            @(posedge clock);
            #1;
            check_value($sformatf("f8_e%0d", n), int'(out8), model(8, n));
            check_value($sformatf("f5_e%0d", n), int'(out5), model(5, n));
            check_value($sformatf("f2_e%0d", n), int'(out2), model(2, n));
        end
    endtask

    initial begin
        int rises;
        int deviations;
        int last_rise;
        int mism;
        logic prev;

        reset = 1'b1;
        #2;

        // Reset hold for 10 cycles, then basic/odd/minimum divide over 40 edges.
        hold_reset(10);
        run_checked(40);

        // Asynchronous reset while F=8 output is high (between edges 5 and 6).
        hold_reset(2);
        run_checked(5);
        check_value("f8_high_before_rst", int'(out8), 1);
        #2;
        reset = 1'b0;
        #1;
        check_value("f8_async_drop", int'(out8), 0);
        check_value("f5_async_drop", int'(out5), 0);
        check_value("f2_async_drop", int'(out2), 0);
        @(negedge clock);
        check_value("f8_still_low", int'(out8), 0);
        reset = 1'b1;
        run_checked(8);

        // Long run at F=8: rise count and period stability.
        hold_reset(1);
        rises      = 0;
        deviations = 0;
        last_rise  = -1;
        mism       = 0;
        prev       = 1'b0;
        for (int n = 1; n <= 10000; n++) begin
            @(posedge clock);
            #1;
            if (int'(out8) != model(8, n)) mism++;
            if (out8 && !prev) begin
                rises++;
                if (last_rise >= 0 && (n - last_rise) != 8) deviations++;
                last_rise = n;
            end
            prev = out8;
        end
        check_value("long_rises", rises, 1250);
        check_value("long_period_dev", deviations, 0);
        check_value("long_waveform_mism", mism, 0);
        check_value("long_first_rise_last", last_rise, 9996);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
